food_map_ctrl: RTL and testbench

FOOD_MAP_CTRL -- requirements
Module: food_map_ctrl

---
 rtl/food_map_ctrl_pkg.sv | 18 +
 rtl/food_map_ctrl_ram.sv | 28 ++
 rtl/food_map_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_food_map_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/food_map_ctrl_pkg.sv
// Shared game constants and the map controller state encoding.
package food_map_ctrl_pkg;

   localparam int          DEF_ROWS  = 50;
   localparam int          DEF_COLS  = 80;
   localparam int          TILE_SIZE = 16;
   localparam logic [15:0] SCORE_MAX = 16'h9999;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      RD,
      MOD,
      WR,
      ACK
   } state_t;

endpackage

// File: rtl/food_map_ctrl_ram.sv
// Single-port food map storage: synchronous write, registered read-first output.
module food_ram
   import food_map_ctrl_pkg::*;
#(
   parameter int ROWS = DEF_ROWS,
   parameter int COLS = DEF_COLS
) (
   input  logic                    clk,
   input  logic                    en,
   input  logic                    we,
   input  logic [$clog2(ROWS)-1:0] addr,
   input  logic [COLS-1:0]         wdata,
   output logic [COLS-1:0]         rdata
);

   logic [COLS-1:0] mem [ROWS];

   // One access per cycle; the read returns the row as it was before any write.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/food_map_ctrl.sv
// Food map controller: INIT sweep, display row reads and atomic eat
// read-modify-write transactions sharing one single-port RAM.
module food_map_ctrl
   import food_map_ctrl_pkg::*;
#(
   parameter int          ROWS       = DEF_ROWS,
   parameter int          COLS       = DEF_COLS,
   parameter logic [11:0] FOOD_TOTAL = 12'd1000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            disp_active,
   input  logic [5:0]      food_idx_y,
   output logic [COLS-1:0] food_row,
   input  logic            eat_req,
   input  logic [6:0]      eat_x,
   input  logic [5:0]      eat_y,
   output logic            eat_ack,
   output logic            eat_hit,
   input  logic            restart,
   output logic [15:0]     score,
   output logic [11:0]     food_left,
   output logic            level_clear,
   output logic            init_busy
);

   localparam int AW = $clog2(ROWS);

   state_t          state, state_nx;
   logic [AW-1:0]   row_cnt;
   logic [6:0]      x_q;
   logic [AW-1:0]   y_q;
   logic [AW-1:0]   disp_y_q;
   logic            disp_rd_q;
   logic            reject_q;
   logic            hit_q;
   logic [COLS-1:0] row_q;
   logic [COLS-1:0] bit_mask;

   logic            in_range;
   logic            take_eat;
   logic            disp_rd;

   logic            ram_en;
   logic            ram_we;
   logic [AW-1:0]   ram_addr;
   logic [COLS-1:0] ram_wdata;
   logic [COLS-1:0] ram_rdata;

   // Four-digit BCD increment with per-digit carry, saturating at 9999.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      if (v == SCORE_MAX) begin
         return v;
      end
      for (int unsigned i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   food_ram #(
      .ROWS(ROWS),
      .COLS(COLS)
   ) u_ram (
      .clk  (clk),
      .en   (ram_en),
      .we   (ram_we),
      .addr (ram_addr),
      .wdata(ram_wdata),
      .rdata(ram_rdata)
   );

   // Request qualification, display arbitration and status outputs.
   always_comb begin
      in_range    = ({1'b0, eat_x} < 8'(COLS)) && ({1'b0, eat_y} < 7'(ROWS));
      take_eat    = (state == IDLE) && eat_req && !disp_active && !eat_ack && !reject_q;
      disp_rd     = (state == IDLE) && disp_active && !reject_q;
      bit_mask    = {{(COLS-1){1'b0}}, 1'b1} << x_q;
      init_busy   = (state == INIT);
      level_clear = (food_left == '0) && (state != INIT);
   end

   // Next-state logic and RAM port steering.
   always_comb begin
      state_nx  = state;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = disp_y_q;
      ram_wdata = row_q & ~bit_mask;
      case (state)
         INIT: begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = row_cnt;
            ram_wdata = '1;
            if (row_cnt == AW'(ROWS - 1)) begin
               state_nx = IDLE;
            end
         end
         IDLE: begin
            if (reject_q) begin
               state_nx = ACK;
            end else if (take_eat && in_range) begin
               state_nx = RD;
            end else if (disp_rd) begin
               ram_en   = 1'b1;
               ram_addr = disp_y_q;
            end
         end
         RD: begin
            ram_en   = 1'b1;
            ram_addr = y_q;
            state_nx = MOD;
         end
         MOD: begin
            state_nx = WR;
         end
         WR: begin
            ram_en   = hit_q;
            ram_we   = hit_q;
            ram_addr = y_q;
            state_nx = ACK;
         end
         ACK: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = INIT;
         end
      endcase
      if (restart) begin
         state_nx = INIT;
         ram_en   = 1'b0;
         ram_we   = 1'b0;
      end
   end

   // State register, transaction datapath, score and food bookkeeping.
   // An out-of-range request spends one IDLE cycle latching the rejection
   // so it acknowledges two cycles after being sampled, without a RAM access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INIT;
         row_cnt   <= '0;
         score     <= '0;
         food_left <= FOOD_TOTAL;
         food_row  <= '0;
         eat_ack   <= 1'b0;
         eat_hit   <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         disp_y_q  <= '0;
         disp_rd_q <= 1'b0;
         reject_q  <= 1'b0;
         hit_q     <= 1'b0;
         row_q     <= '0;
      end else begin
         state     <= state_nx;
         eat_ack   <= 1'b0;
         disp_y_q  <= food_idx_y[AW-1:0];
         disp_rd_q <= disp_rd && !restart;
         if (disp_rd_q) begin
            food_row <= ram_rdata;
         end
         if (restart) begin
            row_cnt   <= '0;
            food_left <= FOOD_TOTAL;
            reject_q  <= 1'b0;
            hit_q     <= 1'b0;
         end else begin
            case (state)
               INIT: begin
                  row_cnt <= (row_cnt == AW'(ROWS - 1)) ? '0 : row_cnt + 1'b1;
               end
               IDLE: begin
                  if (reject_q) begin
                     reject_q <= 1'b0;
                  end else if (take_eat) begin
                     x_q      <= eat_x;
                     y_q      <= eat_y[AW-1:0];
                     hit_q    <= 1'b0;
                     reject_q <= !in_range;
                  end
               end
               MOD: begin
                  row_q <= ram_rdata;
                  hit_q <= |(ram_rdata & bit_mask);
               end
               ACK: begin
                  eat_ack <= 1'b1;
                  eat_hit <= hit_q;
                  if (hit_q) begin
                     score     <= bcd_inc(score);
                     food_left <= (food_left == '0) ? '0 : food_left - 12'd1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_food_map_ctrl.sv
// Directed self-checking bench for food_map_ctrl.
module tb_food_map_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        disp_active;
   logic [5:0]  food_idx_y;
   logic [79:0] food_row;
   logic        eat_req;
   logic [6:0]  eat_x;
   logic [5:0]  eat_y;
   logic        eat_ack;
   logic        eat_hit;
   logic        restart;
   logic [15:0] score;
   logic [11:0] food_left;
   logic        level_clear;
   logic        init_busy;

   int checks = 0;
   int errors = 0;
   int total_hits = 0;
   int misses = 0;
   int cx = 0;
   int cy = 8;

   food_map_ctrl #(
      .ROWS(50),
      .COLS(80),
      .FOOD_TOTAL(12'd1000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .disp_active(disp_active),
      .food_idx_y (food_idx_y),
      .food_row   (food_row),
      .eat_req    (eat_req),
      .eat_x      (eat_x),
      .eat_y      (eat_y),
      .eat_ack    (eat_ack),
      .eat_hit    (eat_hit),
      .restart    (restart),
      .score      (score),
      .food_left  (food_left),
      .level_clear(level_clear),
      .init_busy  (init_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Counts negedges while init_busy stays high, bounded.
   task automatic wait_init(output int n);
      n = 0;
      while (init_busy && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Issues one eat request; lat counts rising edges after the sampling edge.
   task automatic eat(input int x, input int y, input int disp_at, input int rst_at,
                      output int lat, output logic hit, output logic acked);
      eat_x   = 7'(x);
      eat_y   = 6'(y);
      eat_req = 1'b1;
      hit     = 1'b0;
      acked   = 1'b0;
      @(posedge clk);
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         restart = 1'b0;
         if (disp_at > 0 && lat == disp_at) disp_active = 1'b1;
         if (rst_at > 0 && lat == rst_at) restart = 1'b1;
         if (eat_ack) begin
            acked = 1'b1;
            hit   = eat_hit;
            break;
         end
         @(posedge clk);
         lat++;
      end
      eat_req = 1'b0;
      restart = 1'b0;
      @(negedge clk);
   endtask

   // Eats fresh cells from rows 8..49, refilling the level when exhausted.
   task automatic hits_until(input int target);
      int   lat;
      int   n;
      logic hit;
      logic acked;
      while (total_hits < target) begin
         eat(cx, cy, 0, 0, lat, hit, acked);
         if (!(acked && hit && lat == 4)) misses++;
         total_hits++;
         cx++;
         if (cx == 80) begin
            cx = 0;
            cy++;
            if (cy == 50) begin
               cy = 8;
               restart = 1'b1;
               @(negedge clk);
               restart = 1'b0;
               wait_init(n);
               chk("refill_init_len", 80'(n), 80'd50);
            end
         end
      end
   endtask

   initial begin
      int          lat;
      int          n;
      logic        hit;
      logic        acked;
      logic [79:0] all1;
      logic [79:0] one;
      logic [79:0] row7_a;
      logic [79:0] row7_b;

      all1   = '1;
      one    = 80'd1;
      row7_a = all1 & ~(one << 12);
      row7_b = all1 & ~(one << 3);

      rst         = 1'b1;
      disp_active = 1'b0;
      food_idx_y  = '0;
      eat_req     = 1'b0;
      eat_x       = '0;
      eat_y       = '0;
      restart     = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_init_busy", 80'(init_busy), 80'd1);
      chk("rst_score", 80'(score), 80'h0);
      chk("rst_food_left", 80'(food_left), 80'd1000);
      chk("rst_food_row", food_row, 80'h0);
      chk("rst_eat_ack", 80'(eat_ack), 80'd0);
      chk("rst_eat_hit", 80'(eat_hit), 80'd0);

      rst = 1'b0;
      wait_init(n);
      chk("init_len", 80'(n), 80'd50);
      chk("level_clear_full", 80'(level_clear), 80'd0);

      disp_active = 1'b1;
      food_idx_y  = 6'd7;
      repeat (3) @(negedge clk);
      chk("row7_full", food_row, all1);
      disp_active = 1'b0;

      eat(12, 7, 0, 0, lat, hit, acked);
      total_hits = 1;
      chk("eat1_ack", 80'(acked), 80'd1);
      chk("eat1_lat", 80'(lat), 80'd4);
      chk("eat1_hit", 80'(hit), 80'd1);
      chk("eat1_score", 80'(score), 80'h0001);
      chk("eat1_food", 80'(food_left), 80'd999);

      disp_active = 1'b1;
      repeat (3) @(negedge clk);
      chk("row7_bit12_clear", food_row, row7_a);
      disp_active = 1'b0;

      eat(12, 7, 0, 0, lat, hit, acked);
      chk("eat2_lat", 80'(lat), 80'd4);
      chk("eat2_hit", 80'(hit), 80'd0);
      chk("eat2_score", 80'(score), 80'h0001);
      chk("eat2_food", 80'(food_left), 80'd999);

      eat(80, 3, 0, 0, lat, hit, acked);
      chk("oor_x_ack", 80'(acked), 80'd1);
      chk("oor_x_lat", 80'(lat), 80'd2);
      chk("oor_x_hit", 80'(hit), 80'd0);
      eat(5, 50, 0, 0, lat, hit, acked);
      chk("oor_y_lat", 80'(lat), 80'd2);
      chk("oor_y_hit", 80'(hit), 80'd0);
      chk("oor_score", 80'(score), 80'h0001);

      hits_until(99);
      chk("score_0099", 80'(score), 80'h0099);
      hits_until(100);
      chk("score_0100", 80'(score), 80'h0100);
      chk("food_900", 80'(food_left), 80'd900);
      hits_until(1000);
      chk("food_zero", 80'(food_left), 80'd0);
      chk("level_clear", 80'(level_clear), 80'd1);
      hits_until(1001);
      chk("food_sat_zero", 80'(food_left), 80'd0);
      chk("score_1001", 80'(score), 80'h1001);
      hits_until(9999);
      chk("score_9999", 80'(score), 80'h9999);
      hits_until(10000);
      chk("score_sat", 80'(score), 80'h9999);
      chk("bulk_misses", 80'(misses), 80'd0);

      food_idx_y = 6'd7;
      eat(3, 7, 1, 0, lat, hit, acked);
      chk("mid_disp_ack", 80'(acked), 80'd1);
      chk("mid_disp_lat", 80'(lat), 80'd4);
      chk("mid_disp_hit", 80'(hit), 80'd1);
      chk("mid_disp_row_held", food_row, row7_a);
      repeat (3) @(negedge clk);
      chk("mid_disp_row_new", food_row, row7_b);
      disp_active = 1'b0;

      eat(20, 7, 0, 2, lat, hit, acked);
      chk("abort_no_ack", 80'(acked), 80'd0);
      chk("abort_in_init", 80'(init_busy), 80'd1);
      wait_init(n);
      chk("abort_init_done", 80'(init_busy), 80'd0);
      chk("abort_food_reload", 80'(food_left), 80'd1000);
      chk("abort_score_kept", 80'(score), 80'h9999);
      disp_active = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_row7_refill", food_row, all1);
      disp_active = 1'b0;

      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      eat_x   = 7'd21;
      eat_y   = 6'd7;
      eat_req = 1'b1;
      wait_init(n);
      chk("restart_init_len", 80'(n), 80'd50);
      acked = 1'b0;
      for (int k = 0; k < 20 && !acked; k++) begin
         @(negedge clk);
         if (eat_ack) begin
            acked = 1'b1;
            hit   = eat_hit;
         end
      end
      eat_req = 1'b0;
      chk("init_wait_ack", 80'(acked), 80'd1);
      chk("init_wait_hit", 80'(hit), 80'd1);
      chk("init_wait_food", 80'(food_left), 80'd999);
      chk("init_wait_score", 80'(score), 80'h9999);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
